// File: rtl/sweep_pkg.sv
// sweep_pkg: shared types and constants for the sweep_decoder block.
//   sweep_state_t : tracking FSM states (IDLE, ACQ, UP, DOWN, FAULT)
//   ERR_*         : values reported on err_code (first error wins)
package sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,   // no position seen since reset
        ACQ,    // position seen, direction not yet established
        UP,     // moving toward MSB
        DOWN,   // moving toward LSB
        FAULT   // protocol violation seen
    } sweep_state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ONEHOT = 2'b01;
    localparam logic [1:0] ERR_STEP   = 2'b10;

endpackage

// File: rtl/sweep_decoder_onehot_enc.sv
// onehot_enc: combinational one-hot to binary encoder with legality flag.
//   onehot    in  WIDTH  candidate one-hot vector
//   index     out IDX_W  binary index of the set bit (meaningful only when is_onehot)
//   is_onehot out 1      exactly one bit of onehot is set (all-zero is illegal)
module onehot_enc #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] index,
    output logic             is_onehot
);

    // OR-ing the indices of all set bits yields the right index for a
    // legal vector; illegal vectors are flagged separately.
    always_comb begin
        // NOTE: default assignment first so no path leaves index unassigned (no latch).
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) index |= IDX_W'(i);
        end
    end

    // Clearing the lowest set bit leaves zero only when a single bit was set.
    assign is_onehot = (onehot != '0) && ((onehot & (onehot - WIDTH'(1))) == '0);

endmodule

// File: rtl/sweep_decoder.sv
// sweep_decoder: converts the bouncing one-hot position bus into a binary
// index, tracks sweep direction, flags protocol errors and counts round trips.
// Optional feature macro: SWEEP_DEC_RECOVER_EN (a legal position-0 sample
// leaves FAULT and restarts an upward sweep; err/err_code stay sticky).
//   clk          in  1      rising-edge clock
//   reset        in  1      synchronous, active-high
//   pos_valid    in  1      pos is sampled this cycle
//   pos          in  WIDTH  one-hot position
//   idx          out IDX_W  index of last accepted position
//   idx_valid    out 1      pulse: idx updated (including holds)
//   dir          out 1      1 = toward MSB, 0 = toward LSB
//   bounce       out 1      pulse: end-point reversal
//   sweep_count  out CNT_W  completed round trips (wraps)
//   err          out 1      sticky error flag
//   err_code     out 2      first error: 01 not one-hot, 10 illegal step
module sweep_decoder
    import sweep_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int CNT_W = 16,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pos_valid,
    input  logic [WIDTH-1:0] pos,
    output logic [IDX_W-1:0] idx,
    output logic             idx_valid,
    output logic             dir,
    output logic             bounce,
    output logic [CNT_W-1:0] sweep_count,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W:0]   ONE  = (IDX_W + 1)'(1);

    sweep_state_t     state;
    logic [IDX_W-1:0] n;
    logic             legal;

    onehot_enc #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc (
        .onehot    (pos),
        .index     (n),
        .is_onehot (legal)
    );

    // Step tests done one bit wider so p+1 / p-1 never wrap at the ends.
    logic step_up, step_dn, hold, at_first, at_last;
    assign step_up  = ({1'b0, n} == {1'b0, idx} + ONE);
    assign step_dn  = ({1'b0, n} + ONE == {1'b0, idx});
    assign hold     = (n == idx);
    assign at_first = (n == '0);
    assign at_last  = (n == LAST);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            idx_valid   <= 1'b0;
            dir         <= 1'b1;
            bounce      <= 1'b0;
            sweep_count <= '0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            idx_valid <= 1'b0;
            bounce    <= 1'b0;
            if (pos_valid) begin
                if (state == FAULT) begin
`ifdef SWEEP_DEC_RECOVER_EN
                    if (legal && at_first) begin
                        state     <= UP;
                        idx       <= '0;
                        dir       <= 1'b1;
                        idx_valid <= 1'b1;
                    end
`else
                    // Terminal until reset: every sample is ignored.
`endif
                end else if (!legal) begin
                    state <= FAULT;
                    err   <= 1'b1;
                    if (err_code == ERR_NONE) err_code <= ERR_ONEHOT;
                end else if (state == IDLE) begin
                    idx       <= n;
                    idx_valid <= 1'b1;
                    if (at_first) begin
                        state <= UP;
                        dir   <= 1'b1;
                    end else if (at_last) begin
                        state <= DOWN;
                        dir   <= 1'b0;
                    end else begin
                        state <= ACQ;
                    end
                end else if (hold) begin
                    idx_valid <= 1'b1;
                end else if ((state == ACQ && (step_up || step_dn)) ||
                             (state == UP && step_up) ||
                             (state == DOWN && step_dn)) begin
                    idx       <= n;
                    idx_valid <= 1'b1;
                    // Arriving at an end always heads back the other way; it
                    // counts as a bounce only when a direction was established.
                    if (at_last) begin
                        state  <= DOWN;
                        dir    <= 1'b0;
                        bounce <= (state == UP);
                    end else if (at_first) begin
                        state  <= UP;
                        dir    <= 1'b1;
                        bounce <= (state == DOWN);
                        if (state == DOWN) sweep_count <= sweep_count + CNT_W'(1);
                    end else begin
                        state <= step_up ? UP : DOWN;
                        dir   <= step_up;
                    end
                end else begin
                    state <= FAULT;
                    err   <= 1'b1;
                    if (err_code == ERR_NONE) err_code <= ERR_STEP;
                end
            end
        end
    end

endmodule

// File: tb/tb_sweep_decoder.sv
module tb_sweep_decoder;

    localparam int W     = 8;
    localparam int CNT_W = 4;   // narrow counter so wrap-around is reachable
    localparam int IDX_W = $clog2(W);
    localparam int VW    = IDX_W + 1 + 1 + 1 + CNT_W + 1 + 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             pos_valid = 1'b0;
    logic [W-1:0]     pos = '0;
    logic [IDX_W-1:0] idx;
    logic             idx_valid, dir, bounce, err;
    logic [CNT_W-1:0] sweep_count;
    logic [1:0]       err_code;

    int errors = 0;
    int checks = 0;

    sweep_decoder #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .pos_valid   (pos_valid),
        .pos         (pos),
        .idx         (idx),
        .idx_valid   (idx_valid),
        .dir         (dir),
        .bounce      (bounce),
        .sweep_count (sweep_count),
        .err         (err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    // Behavioural model: position walk described by deltas, not states.
    int               m_idx;
    bit               m_seen, m_known, m_fault, m_dir, m_valid, m_bounce, m_err;
    logic [CNT_W-1:0] m_count;
    logic [1:0]       m_code;

    task automatic model_reset();
        m_idx = 0; m_seen = 0; m_known = 0; m_fault = 0; m_dir = 1;
        m_valid = 0; m_bounce = 0; m_err = 0; m_count = '0; m_code = 2'b00;
    endtask

    task automatic model_step(input bit r, input bit v, input logic [W-1:0] p);
        int n, d;
        m_valid = 0;
        m_bounce = 0;
        if (r) begin
            model_reset();
            return;
        end
        if (!v) return;
        if ($countones(p) != 1) begin
            if (!m_fault) begin
                m_fault = 1; m_err = 1;
                if (m_code == 2'b00) m_code = 2'b01;
            end
            return;
        end
        n = $clog2(p);
        if (m_fault) begin
`ifdef SWEEP_DEC_RECOVER_EN
            if (n == 0) begin
                m_fault = 0; m_seen = 1; m_known = 1; m_dir = 1; m_idx = 0; m_valid = 1;
            end
`endif
            return;
        end
        if (!m_seen) begin
            m_seen = 1; m_idx = n; m_valid = 1;
            m_known = (n == 0 || n == W - 1);
            m_dir = (n != W - 1);
            return;
        end
        d = n - m_idx;
        if (d == 0) begin
            m_valid = 1;
        end else if ((d != 1 && d != -1) || (m_known && ((d == 1) != m_dir))) begin
            m_fault = 1; m_err = 1;
            if (m_code == 2'b00) m_code = 2'b10;
        end else begin
            m_bounce = m_known && (n == 0 || n == W - 1);
            if (m_bounce && n == 0) m_count = m_count + 1'b1;
            m_dir = (n == W - 1) ? 1'b0 : (n == 0) ? 1'b1 : (d == 1);
            m_known = 1; m_idx = n; m_valid = 1;
        end
    endtask

    function automatic logic [VW-1:0] dut_vec();
        return {idx, idx_valid, dir, bounce, sweep_count, err, err_code};
    endfunction

    function automatic logic [VW-1:0] mdl_vec();
        return {IDX_W'(m_idx), m_valid, m_dir, m_bounce, m_count, m_err, m_code};
    endfunction

    // One cycle: apply inputs before the edge, outputs are compared at the next negedge.
    task automatic drive(input bit v, input logic [W-1:0] p, input bit r);
        reset = r; pos_valid = v; pos = p;
        model_step(r, v, p);
        @(negedge clk);
    endtask

    task automatic drive_cmp(input string name, input bit v, input logic [W-1:0] p, input bit r);
        drive(v, p, r);
        checks++;
        if (dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL %s pos=%h got {idx,iv,dir,bnc,cnt,err,code}=%h expected %h",
                     name, p, dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        checks++;
        if (dut_vec() !== {3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL reset_values got %h expected %h", dut_vec(),
                     {3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 2'b00});
        end
    endtask

    task automatic round_trip();
        for (int i = 1; i < W; i++) drive_cmp("trip_up", 1'b1, W'(1) << i, 1'b0);
        for (int i = W - 2; i >= 0; i--) drive_cmp("trip_down", 1'b1, W'(1) << i, 1'b0);
    endtask

    task automatic test_sweep();
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < W; i++) drive_cmp("sweep_up", 1'b1, W'(1) << i, 1'b0);
        checks++;
        if (idx !== 3'd7 || bounce !== 1'b1 || dir !== 1'b0 || sweep_count !== 4'd0) begin
            errors++;
            $display("FAIL top_bounce idx=%0d bounce=%b dir=%b cnt=%0d expected 7 1 0 0",
                     idx, bounce, dir, sweep_count);
        end
        for (int i = W - 2; i >= 0; i--) drive_cmp("sweep_down", 1'b1, W'(1) << i, 1'b0);
        checks++;
        if (idx !== 3'd0 || bounce !== 1'b1 || dir !== 1'b1 || sweep_count !== 4'd1) begin
            errors++;
            $display("FAIL bottom_bounce idx=%0d bounce=%b dir=%b cnt=%0d expected 0 1 1 1",
                     idx, bounce, dir, sweep_count);
        end
        round_trip();
        round_trip();
        checks++;
        if (sweep_count !== 4'd3) begin
            errors++;
            $display("FAIL three_trips cnt=%0d expected 3", sweep_count);
        end
        // 14 more round trips: 17 modulo 16.
        for (int t = 0; t < 14; t++) round_trip();
        checks++;
        if (sweep_count !== 4'd1 || err !== 1'b0) begin
            errors++;
            $display("FAIL count_wrap cnt=%0d err=%b expected 1 0", sweep_count, err);
        end
    endtask

    task automatic test_acquire();
        drive(1'b0, '0, 1'b1);
        drive_cmp("acq_first", 1'b1, 8'h10, 1'b0);
        drive_cmp("acq_second", 1'b1, 8'h08, 1'b0);
        checks++;
        if (idx !== 3'd3 || dir !== 1'b0 || bounce !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL acquire idx=%0d dir=%b bounce=%b err=%b expected 3 0 0 0",
                     idx, dir, bounce, err);
        end
        drive_cmp("acq_hold", 1'b1, 8'h08, 1'b0);
        drive_cmp("acq_gap", 1'b0, 8'h01, 1'b0);
    endtask

    task automatic test_onehot_err();
        drive(1'b0, '0, 1'b1);
        drive_cmp("oh_a", 1'b1, 8'h01, 1'b0);
        drive_cmp("oh_b", 1'b1, 8'h02, 1'b0);
        drive_cmp("oh_bad", 1'b1, 8'h06, 1'b0);
        checks++;
        if (err !== 1'b1 || err_code !== 2'b01 || idx !== 3'd1 || idx_valid !== 1'b0) begin
            errors++;
            $display("FAIL onehot_err err=%b code=%b idx=%0d iv=%b expected 1 01 1 0",
                     err, err_code, idx, idx_valid);
        end
        drive_cmp("oh_after", 1'b1, 8'h01, 1'b0);
`ifdef SWEEP_DEC_RECOVER_EN
        checks++;
        if (idx !== 3'd0 || idx_valid !== 1'b1 || err !== 1'b1 || dir !== 1'b1) begin
            errors++;
            $display("FAIL recover idx=%0d iv=%b err=%b dir=%b expected 0 1 1 1",
                     idx, idx_valid, err, dir);
        end
`else
        checks++;
        if (idx !== 3'd1 || idx_valid !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL fault_terminal idx=%0d iv=%b err=%b expected 1 0 1", idx, idx_valid, err);
        end
`endif
    endtask

    task automatic test_step_err();
        drive(1'b0, '0, 1'b1);
        drive_cmp("st_a", 1'b1, 8'h04, 1'b0);
        drive_cmp("st_jump", 1'b1, 8'h20, 1'b0);
        drive_cmp("st_zero", 1'b1, 8'h00, 1'b0);
        checks++;
        if (err !== 1'b1 || err_code !== 2'b10 || idx !== 3'd2) begin
            errors++;
            $display("FAIL step_err err=%b code=%b idx=%0d expected 1 10 2", err, err_code, idx);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < W; i++) drive_cmp("mid_up", 1'b1, W'(1) << i, 1'b0);
        drive_cmp("mid_down", 1'b1, 8'h40, 1'b0);
        drive_cmp("mid_reset", 1'b1, 8'h80, 1'b1);
        checks++;
        if (dut_vec() !== {3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL reset_mid got %h expected %h", dut_vec(),
                     {3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 2'b00});
        end
        // A mid-range first sample is only legal when re-acquiring from IDLE.
        drive_cmp("reacq", 1'b1, 8'h10, 1'b0);
        checks++;
        if (idx !== 3'd4 || idx_valid !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL reacquire idx=%0d iv=%b err=%b expected 4 1 0", idx, idx_valid, err);
        end
    endtask

    task automatic test_random();
        int nxt;
        logic [W-1:0] p;
        drive(1'b0, '0, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            int roll = $urandom_range(99);
            if (roll < 2) begin
                drive_cmp("rnd_reset", $urandom_range(1) == 1, W'($urandom), 1'b1);
            end else if (roll < 15) begin
                drive_cmp("rnd_gap", 1'b0, W'($urandom), 1'b0);
            end else if (roll < 18) begin
                drive_cmp("rnd_junk", 1'b1, W'($urandom), 1'b0);
            end else begin
                if (m_fault) nxt = ($urandom_range(2) == 0) ? 0 : $urandom_range(W - 1);
                else if (!m_seen) nxt = $urandom_range(W - 1);
                else if (roll < 30) nxt = m_idx;
                else if (m_known) nxt = m_dir ? m_idx + 1 : m_idx - 1;
                else if (m_idx == 0) nxt = 1;
                else if (m_idx == W - 1) nxt = W - 2;
                else nxt = ($urandom_range(1) == 1) ? m_idx + 1 : m_idx - 1;
                p = W'(1) << nxt;
                drive_cmp("rnd_walk", 1'b1, p, 1'b0);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sweep();
        test_acquire();
        test_onehot_err();
        test_step_err();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sweep_decoder.md
# sweep_decoder

Consumes the 8-bit bouncing one-hot position bus produced by the shift counter stage and converts it to a binary index with tracked sweep direction. It checks every sample for legal one-hot encoding and legal single-step movement, pulses on each end-point reversal, and counts completed round trips. It sits directly downstream of the shift counter and feeds display/status logic.

## Interface
- `WIDTH`, 8: width of the one-hot position bus; must be ≥ 3.
- `CNT_W`, 16: width of the round-trip counter.
- `IDX_W`, `$clog2(WIDTH)`: derived index width; not overridden.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `pos_valid`  in  1  the position sample on `pos` is taken this cycle.
- `pos`  in  WIDTH  one-hot position from the upstream counter.
- `idx`  out  IDX_W  binary index of the last accepted position.
- `idx_valid`  out  1  one-cycle pulse when `idx` has been updated.
- `dir`  out  1  1 = moving toward MSB, 0 = moving toward LSB.
- `bounce`  out  1  one-cycle pulse on an end-point reversal.
- `sweep_count`  out  CNT_W  completed round trips; wraps modulo 2^CNT_W.
- `err`  out  1  sticky error flag.
- `err_code`  out  2  first error captured: 00 none, 01 not one-hot (includes all-zero), 10 illegal step.

## Operation
- The FSM has five states: IDLE, ACQ, UP, DOWN and FAULT. Cycles with `pos_valid` = 0 change nothing.
- Every valid sample is checked for one-hot encoding first. A failing sample moves the FSM to FAULT and sets `err`. If `err_code` is 00, it is set to 01. `idx` is not updated.
- For a legal sample, n = encoded index and p = the stored `idx`.
- IDLE:
  - n = 0: go to UP.
  - n = WIDTH-1: go to DOWN.
  - Otherwise: go to ACQ.
  - No bounce is generated from IDLE.
- ACQ:
  - n = p+1: go to UP.
  - n = p-1: go to DOWN.
  - n = p: stay in ACQ.
  - Otherwise: illegal step.
- UP:
  - n = p+1 is legal. If n = WIDTH-1, go to DOWN, clear `dir` and pulse `bounce`.
- DOWN:
  - n = p-1 is legal. If n = 0, go to UP, set `dir`, pulse `bounce` and increment `sweep_count`.
- In any tracking state, n = p is a hold: it is accepted, `idx_valid` pulses, and nothing else changes.
- Illegal step: go to FAULT and set `err`. If `err_code` is 00, it is set to 10. `idx` is not updated.
- `idx_valid` pulses for every accepted legal sample, including holds.
- `err` and `err_code` are cleared only by reset.

## Timing
- All outputs are registered. Latency is 1 cycle from the `pos_valid` sample edge to `idx`, `idx_valid`, `dir`, `bounce` and `sweep_count`.
- Back-to-back `pos_valid` on every cycle is supported at full rate.
- Reset values:
  - state IDLE
  - `idx` = 0, `dir` = 1
  - `idx_valid` = 0, `bounce` = 0
  - `sweep_count` = 0
  - `err` = 0, `err_code` = 00
- Reset wins over `pos_valid` in the same cycle, and the sample is dropped.
- Reset mid-sweep returns the block to IDLE. The next sample re-acquires position.
- `sweep_count` wraps from 2^CNT_W-1 to 0 with no flag.

## Configuration
- `SWEEP_DEC_RECOVER_EN` defined: in FAULT, a legal sample with n = 0 goes to UP with `idx` = 0 and `dir` = 1, and `idx_valid` pulses. `err` and `err_code` stay sticky.
- Not defined: FAULT is terminal until reset, and all samples are ignored.

## Structure
- Package `sweep_pkg` holds:
  - the state enum `sweep_state_t` (IDLE, ACQ, UP, DOWN, FAULT)
  - the error-code constants `ERR_NONE`, `ERR_ONEHOT` and `ERR_STEP`
- Sub-module `onehot_enc` is combinational. It takes WIDTH-bit one-hot input and outputs the binary index plus an `is_onehot` flag.
- The top level holds the FSM, step comparison, counters and output registers.

## Test plan
- Reset, then samples 0x01, 0x02 … 0x80 → `idx` steps 0..7 with `dir` = 1. At 0x80 there is one `bounce` pulse and `dir` = 0. `sweep_count` = 0.
- Continue 0x40 … 0x01 → `idx` 6..0. At 0x01 there is a `bounce` pulse, `dir` = 1 and `sweep_count` = 1. Three full round trips give `sweep_count` = 3.
- First sample 0x10 then 0x08 → the FSM passes through ACQ, `idx` = 3 and `dir` = 0, with no bounce and no error.
- Sample 0x06 while in UP → `err` = 1, `err_code` = 01, `idx` is unchanged. A following 0x01:
  - with `SWEEP_DEC_RECOVER_EN`: `idx` = 0, `idx_valid` pulses, `err` stays 1.
  - without it: no response.
- Sample 0x04 then 0x20 → `err_code` = 10. A later 0x00 sample keeps `err_code` = 10.
- Assert `reset` together with `pos_valid` and 0x80 mid-sweep → all outputs return to their reset values, the state is IDLE, and there is no `idx_valid` pulse.
